// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_sched_if.sv
// Consumer-side byte handshake of the UART receiver.
interface uart_rx_sched_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEFAULT
);
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;

    // receiver side
    modport master (
        output rx_data, rx_valid, frame_err, overrun,
        input  rx_ack
    );

    // consumer side
    modport slave (
        input  rx_data, rx_valid, frame_err, overrun,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_sched_sync_fall_det.sv
// Synchroniser for the raw rx line plus a 1->0 edge detector on its output.
module sync_fall_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync_q,
    output logic fall
);
    logic [STAGES-1:0] sync_ff_q, sync_ff_d;
    logic              prev_q, prev_d;

    // Shift the line through the chain; remember the previous synchronised value.
    always_comb begin
        sync_ff_d = {sync_ff_q[STAGES-2:0], d};
        prev_d    = sync_ff_q[STAGES-1];
    end

    // Flops reset to the idle-high line level so reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff_q <= '1;
            prev_q    <= 1'b1;
        end else begin
            sync_ff_q <= sync_ff_d;
            prev_q    <= prev_d;
        end
    end

    assign sync_q = sync_ff_q[STAGES-1];
    assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_sched.sv
// Receive sequencer: frames rx using the external baud generator strobes and
// hands assembled bytes to the consumer through a valid/ack holding register.
module uart_rx_sched
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic counter_en,
    input  logic rx_read,
    output logic tick_en,
    output logic busy,
    uart_rx_sched_if.master rx_if
);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 false_start_q, false_start_d;
    logic                 stop_bit_q, stop_bit_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q, ferr_d;
    logic                 tick_en_q, tick_en_d;
    logic                 load;
    logic                 rx_s, rx_fall;

    sync_fall_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (rx),
        .sync_q (rx_s),
        .fall   (rx_fall)
    );

    // Frame sequencing plus holding-register update.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        false_start_d = false_start_q;
        stop_bit_d    = stop_bit_q;
        data_d        = data_q;
        valid_d       = valid_q;
        ovr_d         = ovr_q;
        ferr_d        = 1'b0;
        load          = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d       = START;
                    false_start_d = 1'b0;
                end
            end
            START: begin
                // A high mid-bit sample means a glitch; still finish the period
                // so the generator wraps back to 0.
                if (rx_read && rx_s) false_start_d = 1'b1;
                if (counter_en) begin
                    state_d   = false_start_q ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (rx_read) shift_d = (shift_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
                if (counter_en) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: begin
                if (rx_read) stop_bit_d = rx_s;
                if (counter_en) begin
                    state_d = IDLE;
                    if (stop_bit_q) load = 1'b1;
                    else            ferr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_ack_i() && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        // A load in the same clk as an ack wins and is not counted as lost.
        if (load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack_i()) ovr_d = 1'b1;
        end

        tick_en_d = (state_d != IDLE);
    end

    function automatic logic rx_ack_i();
        return rx_if.rx_ack;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            false_start_q <= 1'b0;
            stop_bit_q    <= 1'b0;
            valid_q       <= 1'b0;
            ovr_q         <= 1'b0;
            ferr_q        <= 1'b0;
            tick_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            false_start_q <= false_start_d;
            stop_bit_q    <= stop_bit_d;
            valid_q       <= valid_d;
            ovr_q         <= ovr_d;
            ferr_q        <= ferr_d;
            tick_en_q     <= tick_en_d;
        end
    end

    assign tick_en         = tick_en_q;
    assign busy            = tick_en_q;
    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_sched.sv
// Bench for uart_rx_sched with a behavioural baud generator (SIZE=16).
module tb_uart_rx_sched;
    localparam int SIZE = 16;
    localparam int DB   = 8;
    localparam int SYNC = 2;

    typedef struct {
        logic [DB-1:0] data;
        logic          valid;
        logic          ferr;
        logic          ovr;
        int            t_end;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic counter_en, rx_read, tick_en, busy;
    int   gcnt;
    int   cyc = 0;
    int   ce_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic busy_prev = 1'b0;

    logic [DB-1:0] m_data;
    logic          m_valid, m_ovr;

    uart_rx_sched_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_sched #(.DATA_BITS(DB), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .counter_en (counter_en),
        .rx_read    (rx_read),
        .tick_en    (tick_en),
        .busy       (busy),
        .rx_if      (rx_if.master)
    );

    always #5 clk = ~clk;

    // baud generator model: counts while enabled, wraps at SIZE-1
    always @(posedge clk or posedge rst) begin
        if (rst)          gcnt <= 0;
        else if (tick_en) gcnt <= (gcnt == SIZE - 1) ? 0 : gcnt + 1;
    end
    assign counter_en = tick_en && (gcnt == SIZE - 1);
    assign rx_read    = tick_en && (gcnt == SIZE / 2 - 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!busy)           ce_cnt <= 0;
        else if (counter_en) ce_cnt <= ce_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // scoreboard: every frame end (busy falls) pops one expected snapshot
    always @(negedge clk) begin
        if (rst) busy_prev = 1'b0;
        else begin
            if (busy_prev && !busy) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    chk("rx_data",   rx_if.rx_data,   mon_e.data);
                    chk("rx_valid",  rx_if.rx_valid,  mon_e.valid);
                    chk("frame_err", rx_if.frame_err, mon_e.ferr);
                    chk("overrun",   rx_if.overrun,   mon_e.ovr);
                    chk("tick_off",  tick_en,         0);
                    chk("gen_zero",  gcnt,            0);
                    chk("latency",   cyc,             mon_e.t_end);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (SIZE) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 4 * SIZE) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input bit ack_load);
        exp_t e;
        if (stop) begin
            if (ack_load)     m_ovr = 1'b0;
            else if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = d;
        end
        e.data  = m_data;
        e.valid = m_valid;
        e.ovr   = m_ovr;
        e.ferr  = !stop;
        e.t_end = cyc + (DB + 2) * SIZE + SYNC + 1;
        sb.push_back(e);
        fork
            begin
                drive_bit(1'b0);
                for (int i = 0; i < DB; i++) drive_bit(d[i]);
                drive_bit(stop);
                rx = 1'b1;
            end
            if (ack_load) begin
                int k = 0;
                while (!(counter_en && ce_cnt == DB + 1) && k < 20 * SIZE) begin
                    @(negedge clk);
                    k++;
                end
                chk("ack_arm", counter_en, 1);
                rx_if.rx_ack = 1'b1;
                @(negedge clk);
                rx_if.rx_ack = 1'b0;
            end
        join
        wait_idle();
        @(negedge clk);
        chk("ferr_pulse", rx_if.frame_err, 0);
    endtask

    task automatic glitch();
        exp_t e;
        e.data  = m_data;
        e.valid = m_valid;
        e.ovr   = m_ovr;
        e.ferr  = 1'b0;
        e.t_end = cyc + SIZE + SYNC + 1;
        sb.push_back(e);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy", busy, 1);
        wait_idle();
        @(negedge clk);
    endtask

    task automatic do_ack();
        rx_if.rx_ack = 1'b1;
        @(negedge clk);
        rx_if.rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        chk("ack_valid",   rx_if.rx_valid, m_valid);
        chk("ack_overrun", rx_if.overrun,  m_ovr);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_tick_en"},  tick_en,         0);
        chk({pfx, "_busy"},     busy,            0);
        chk({pfx, "_data"},     rx_if.rx_data,   0);
        chk({pfx, "_valid"},    rx_if.rx_valid,  0);
        chk({pfx, "_ferr"},     rx_if.frame_err, 0);
        chk({pfx, "_overrun"},  rx_if.overrun,   0);
    endtask

    // abort a frame in DATA bit 4 with an asynchronous reset
    task automatic reset_mid();
        logic [DB-1:0] d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (SIZE / 2) @(negedge clk);
        chk("pre_rst_busy",  busy,           1);
        chk("pre_rst_valid", rx_if.rx_valid, 1);
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst");
        rx = 1'b1;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);
    endtask

    initial begin
        rst          = 1'b1;
        rx           = 1'b1;
        rx_if.rx_ack = 1'b0;
        m_data       = '0;
        m_valid      = 1'b0;
        m_ovr        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        do_ack();
        glitch();
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0);
        do_ack();
        send_frame(8'h55, 1'b1, 1'b0);
        do_ack();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        do_ack();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        reset_mid();
        send_frame(8'hF0, 1'b1, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_sched.md
Name: uart_rx_sched

Overview:
- Receive-side sequencer for the baud tick generator `gen_counter_en`. It drives the generator's `en` and consumes its `counter_en` (bit-period end) and `rx_read` (mid-bit strobe).
- Detects the start bit, samples START/DATA/STOP at mid-bit, assembles an LSB-first byte and presents it through a valid/ack holding register.
- Sits between the `rx` pin and the command/display logic of the UART path.

Parameters:
- DATA_BITS, 8, data bits per frame (1..8); width of `rx_data` and the shift register.
- SYNC_STAGES, 2, flops in the `rx` input synchroniser (at least 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  raw serial line, idle high, asynchronous to clk.
- counter_en  in  1  from `gen_counter_en`; high on the last clk of each bit period.
- rx_read  in  1  from `gen_counter_en`; high on the mid-bit clk.
- tick_en  out  1  to `gen_counter_en.en`; registered.
- rx_data  out  DATA_BITS  last good byte; held until overwritten.
- rx_valid  out  1  level; high while `rx_data` is unread.
- rx_ack  in  1  consumer read; clears `rx_valid`.
- frame_err  out  1  one-clk pulse: stop bit sampled 0.
- overrun  out  1  sticky; set when a byte is lost; cleared by `rx_ack`.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, synchroniser flops=1, `tick_en`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, bit counter=0, shift register=0.
- Input conditioning: `rx` passes through SYNC_STAGES flops. A falling edge is detected on the synchronised signal (previous=1, current=0).
- State machine: IDLE, START, DATA, STOP. `tick_en` and `busy` are registered and equal (next_state != IDLE).
- IDLE: on a falling edge go to START. `tick_en` rises on the same edge, so the generator begins counting from 0.
- START: on `rx_read`, a sampled line of 1 sets the internal `false_start` flag. On `counter_en`, go to IDLE if `false_start` is set, otherwise go to DATA with bit counter=0. Invalid starts are never aborted mid-period.
- DATA: on `rx_read`, shift the sample into the MSB of the shift register and shift right, giving LSB-first assembly. On `counter_en`, increment the bit counter; on the counter_en that ends bit DATA_BITS-1, go to STOP.
- STOP: on `rx_read`, latch the stop sample. On `counter_en`, go to IDLE, then:
  - If stop=1: load `rx_data` from the shift register and set `rx_valid`=1. If `rx_valid` was already 1 and `rx_ack` is low that clk, also set `overrun`=1; the new byte overwrites the old one.
  - If stop=0: pulse `frame_err` for 1 clk; `rx_data` and `rx_valid` are unchanged.
- Counter-phase invariant: `tick_en` falls on the clk after the terminating `counter_en`. The generator has wrapped to 0 on that same edge, so it always rests at 0 in IDLE. The block relies on this and never needs to reset the generator.
- Latency: `rx_valid` rises on the clk after the stop-bit `counter_en`. That is (DATA_BITS+2)×SIZE+SYNC_STAGES+1 clks after the line falls.
- `rx_ack` while `rx_valid`=1: `rx_valid`=0 and `overrun`=0 next clk.
  - Simultaneous `rx_ack` and a good-byte load: the load wins, `rx_valid` stays 1, `overrun` is not set.
  - `rx_ack` while `rx_valid`=0: no effect.
- Line low at the end of STOP (break or back-to-back frame): IDLE requires a fresh 1→0 edge, so a stuck-low line does not retrigger.
- `rx_read` and `counter_en` are never high in the same clk when SIZE≥2. SIZE=1 is unsupported.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The generator must share `rst`.

Decomposition:
- Shared package (`uart_pkg`): state encoding IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3, and DATA_BITS_DEFAULT=8.
- The synchroniser plus falling-edge detector is a natural sub-module, `sync_fall_det` (parameter STAGES; outputs `sync_q`, `fall`).
- `gen_counter_en` stays external. It is instantiated beside this block at the UART top, with its `en` wired to `tick_en`.

Test Plan:
- SIZE=16, DATA_BITS=8: send 0xA5 with stop=1 → `rx_data`=0xA5 and `rx_valid`=1 one clk after the 10th `counter_en`; `frame_err`=0; `tick_en`=0 next clk; generator count=0.
- 4-clk low glitch on `rx` while idle → `false_start`; return to IDLE after one bit period; `rx_valid` stays 0 and the next frame 0x3C decodes correctly.
- Frame 0x81 with stop bit forced 0 → `frame_err` is a 1-clk pulse; `rx_valid`/`rx_data` keep their prior values; a following 0x55 is received correctly.
- Two frames 0x11 then 0x22 with no `rx_ack` → `rx_data`=0x22, `overrun`=1; `rx_ack` → `rx_valid`=0 and `overrun`=0.
- `rx_ack` asserted on the exact clk 0x22 loads while 0x11 is pending → `rx_valid`=1, `overrun`=0, `rx_data`=0x22.
- Assert `rst` during DATA bit 4 → all outputs at reset values within the same clk. Release rst, then send 0xF0 → received correctly.
